// File: rtl/sr_pulse_driver.sv
// sr_pulse_driver: drives the S/R inputs of an external set/reset latch with
// fixed-width pulses followed by a dead interval, tracking the level it last
// drove. Optional feedback check against the latch output is enabled by
// defining SR_DRV_FBCHECK_EN; without it q_fb is unused and err stays 0.
module sr_pulse_driver #(
  parameter int PULSE_W = 2,
  parameter int DEAD_T  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic target,
  input  logic q_fb,
  output logic ready,
  output logic s,
  output logic r,
  output logic done,
  output logic q_model,
  output logic known,
  output logic err
);

  typedef enum logic [1:0] {IDLE, PULSE, DEAD, DONE} state_t;

  localparam logic [3:0] PulseLast = 4'(PULSE_W);
  localparam logic [3:0] DeadLast  = 4'(DEAD_T);

  state_t     state_q, state_d;
  logic [3:0] pcnt_q, pcnt_d;
  logic [3:0] dcnt_q, dcnt_d;
  logic       tgt_q, tgt_d;
  logic       q_model_q, q_model_d;
  logic       known_q, known_d;
  logic       s_q, s_d;
  logic       r_q, r_d;
  logic       fb_mis;

`ifdef SR_DRV_FBCHECK_EN
  logic       err_q, err_d;
  // Latch output disagreeing with the recorded level while completing.
  assign fb_mis = (state_q == DONE) && (q_fb != q_model_q);
`else
  logic       unused_fb;
  assign unused_fb = q_fb;
  assign fb_mis    = 1'b0;
`endif

  // Next-state, counter and drive computation.
  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    dcnt_d    = dcnt_q;
    tgt_d     = tgt_q;
    q_model_d = q_model_q;
    known_d   = known_q;
`ifdef SR_DRV_FBCHECK_EN
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          tgt_d = target;
          // Skip the pulse when the latch is already known to hold the level.
          if (!known_q || (target != q_model_q)) begin
            state_d = PULSE;
            pcnt_d  = 4'd1;
          end else begin
            state_d = DONE;
          end
        end
      end
      PULSE: begin
        if (pcnt_q == PulseLast) begin
          state_d   = DEAD;
          pcnt_d    = 4'd0;
          dcnt_d    = 4'd1;
          q_model_d = tgt_q;
          known_d   = 1'b1;
        end else begin
          pcnt_d = pcnt_q + 4'd1;
        end
      end
      DEAD: begin
        if (dcnt_q == DeadLast) begin
          state_d = DONE;
          dcnt_d  = 4'd0;
        end else begin
          dcnt_d = dcnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef SR_DRV_FBCHECK_EN
        err_d   = err_q | fb_mis;
`endif
      end
      default: state_d = IDLE;
    endcase
    // s and r derive from one target bit, so they can never coincide.
    s_d = (state_d == PULSE) && tgt_d;
    r_d = (state_d == PULSE) && !tgt_d;
  end

  // State and output registers; reset wins over any same-edge acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pcnt_q    <= 4'd0;
      dcnt_q    <= 4'd0;
      tgt_q     <= 1'b0;
      q_model_q <= 1'b0;
      known_q   <= 1'b0;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
`ifdef SR_DRV_FBCHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      dcnt_q    <= dcnt_d;
      tgt_q     <= tgt_d;
      q_model_q <= q_model_d;
      known_q   <= known_d;
      s_q       <= s_d;
      r_q       <= r_d;
`ifdef SR_DRV_FBCHECK_EN
      err_q     <= err_d;
`endif
    end
  end

  assign ready   = (state_q == IDLE);
  assign done    = (state_q == DONE);
  assign s       = s_q;
  assign r       = r_q;
  assign q_model = q_model_q;
  assign known   = known_q;
`ifdef SR_DRV_FBCHECK_EN
  // Visible from the DONE cycle itself, then held until reset.
  assign err     = err_q | fb_mis;
`else
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Directed testbench for sr_pulse_driver (PULSE_W=2, DEAD_T=1) with an ideal
// S/R latch on the feedback path. Honors SR_DRV_FBCHECK_EN for err expectations.
module tb_sr_pulse_driver;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req = 1'b0;
  logic target = 1'b0;
  logic q_fb;
  logic ready, s, r, done, q_model, known, err;
  logic latch_q = 1'b0;
  logic fb_stuck = 1'b0;
  int checks = 0;
  int failures = 0;

`ifdef SR_DRV_FBCHECK_EN
  localparam logic ErrExp = 1'b1;
`else
  localparam logic ErrExp = 1'b0;
`endif

  sr_pulse_driver #(.PULSE_W(2), .DEAD_T(1)) dut (
    .clk(clk), .rst(rst), .req(req), .target(target), .q_fb(q_fb),
    .ready(ready), .s(s), .r(r), .done(done), .q_model(q_model),
    .known(known), .err(err)
  );

  always #5 clk = ~clk;

  always @(s or r) begin
    if (s) latch_q = 1'b1;
    else if (r) latch_q = 1'b0;
  end
  assign q_fb = fb_stuck ? 1'b0 : latch_q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; step(); rst = 1'b0;
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if ({s, r, done} !== 3'b000) begin failures++; $display("FAIL reset_srdone got=%b exp=000", {s, r, done}); end
    checks++; if ({q_model, known, err} !== 3'b000) begin failures++; $display("FAIL reset_state got=%b exp=000", {q_model, known, err}); end
  endtask

  task automatic test_first_reset_cmd();
    req = 1'b1; target = 1'b0; step(); req = 1'b0;
    checks++; if ({s, r, ready} !== 3'b010) begin failures++; $display("FAIL first_c1 got=%b exp=010", {s, r, ready}); end
    step();
    checks++; if ({s, r} !== 2'b01) begin failures++; $display("FAIL first_c2 got=%b exp=01", {s, r}); end
    step();
    checks++; if ({s, r, done, ready} !== 4'b0000) begin failures++; $display("FAIL first_dead got=%b exp=0000", {s, r, done, ready}); end
    step();
    checks++; if ({done, ready} !== 2'b10) begin failures++; $display("FAIL first_done got=%b exp=10", {done, ready}); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL first_err got=%b exp=0", err); end
    step();
    checks++; if ({ready, done, q_model, known} !== 4'b1001) begin failures++; $display("FAIL first_end got=%b exp=1001", {ready, done, q_model, known}); end
  endtask

  task automatic test_set_and_skip();
    req = 1'b1; target = 1'b1; step(); req = 1'b0;
    checks++; if ({s, r} !== 2'b10) begin failures++; $display("FAIL set_c1 got=%b exp=10", {s, r}); end
    step();
    checks++; if ({s, r} !== 2'b10) begin failures++; $display("FAIL set_c2 got=%b exp=10", {s, r}); end
    step();
    checks++; if ({s, r, done} !== 3'b000) begin failures++; $display("FAIL set_dead got=%b exp=000", {s, r, done}); end
    step();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL set_done got=%b exp=1", done); end
    step();
    checks++; if ({ready, q_model, known} !== 3'b111) begin failures++; $display("FAIL set_end got=%b exp=111", {ready, q_model, known}); end
    req = 1'b1; target = 1'b1; step(); req = 1'b0;
    checks++; if ({done, s, r, ready} !== 4'b1000) begin failures++; $display("FAIL skip_done got=%b exp=1000", {done, s, r, ready}); end
    step();
    checks++; if ({ready, done, s, r, q_model} !== 5'b10001) begin failures++; $display("FAIL skip_end got=%b exp=10001", {ready, done, s, r, q_model}); end
  endtask

  task automatic test_back_to_back();
    int last = 0;
    int accepts = 1;
    int s_run = 0;
    int r_run = 0;
    req = 1'b1; target = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      checks++; if (s && r) begin failures++; $display("FAIL b2b_overlap cyc=%0d got=11 exp=not both", i); end
      if (s) s_run++;
      else if (s_run != 0) begin
        checks++; if (s_run != 2) begin failures++; $display("FAIL b2b_s_width got=%0d exp=2", s_run); end
        s_run = 0;
      end
      if (r) r_run++;
      else if (r_run != 0) begin
        checks++; if (r_run != 2) begin failures++; $display("FAIL b2b_r_width got=%0d exp=2", r_run); end
        r_run = 0;
      end
      if (ready) begin
        checks++; if (i - last != 5) begin failures++; $display("FAIL b2b_period got=%0d exp=5", i - last); end
        last = i;
        target = ~target;
        if (i < 20) accepts++;
      end
    end
    req = 1'b0;
    checks++; if (accepts != 4) begin failures++; $display("FAIL b2b_accepts got=%0d exp=4", accepts); end
    checks++; if ({ready, q_model, known} !== 3'b111) begin failures++; $display("FAIL b2b_end got=%b exp=111", {ready, q_model, known}); end
  endtask

  task automatic test_ignore_while_busy();
    req = 1'b1; target = 1'b0; step(); target = 1'b1;
    checks++; if ({s, r} !== 2'b01) begin failures++; $display("FAIL busy_c1 got=%b exp=01", {s, r}); end
    step();
    checks++; if ({s, r} !== 2'b01) begin failures++; $display("FAIL busy_c2 got=%b exp=01", {s, r}); end
    step(); step();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL busy_done got=%b exp=1", done); end
    req = 1'b0; step();
    checks++; if ({ready, q_model, s, r} !== 4'b1000) begin failures++; $display("FAIL busy_end got=%b exp=1000", {ready, q_model, s, r}); end
  endtask

  task automatic test_reset_mid_pulse();
    logic seen_done = 1'b0;
    req = 1'b1; target = 1'b1; step(); req = 1'b0;
    checks++; if (s !== 1'b1) begin failures++; $display("FAIL midrst_c1 got=%b exp=1", s); end
    step();
    checks++; if (s !== 1'b1) begin failures++; $display("FAIL midrst_c2 got=%b exp=1", s); end
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if ({s, r, ready, known, done} !== 5'b00100) begin failures++; $display("FAIL midrst_after got=%b exp=00100", {s, r, ready, known, done}); end
    for (int i = 0; i < 4; i++) begin step(); if (done) seen_done = 1'b1; end
    checks++; if (seen_done !== 1'b0) begin failures++; $display("FAIL midrst_nodone got=%b exp=0", seen_done); end
  endtask

  task automatic test_reset_with_accept();
    rst = 1'b1; req = 1'b1; target = 1'b1; step(); rst = 1'b0; req = 1'b0;
    checks++; if ({ready, s, r} !== 3'b100) begin failures++; $display("FAIL rstacc_c1 got=%b exp=100", {ready, s, r}); end
    step();
    checks++; if ({ready, s, r, done} !== 4'b1000) begin failures++; $display("FAIL rstacc_c2 got=%b exp=1000", {ready, s, r, done}); end
  endtask

  task automatic test_fbcheck();
    fb_stuck = 1'b1;
    req = 1'b1; target = 1'b1; step(); req = 1'b0;
    step();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL fb_pre got=%b exp=0", err); end
    step(); step();
    checks++; if ({done, err} !== {1'b1, ErrExp}) begin failures++; $display("FAIL fb_done got=%b exp=%b", {done, err}, {1'b1, ErrExp}); end
    fb_stuck = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++; if (err !== ErrExp) begin failures++; $display("FAIL fb_sticky got=%b exp=%b", err, ErrExp); end
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL fb_clear got=%b exp=0", err); end
  endtask

  initial begin
    step();
    test_reset();
    test_first_reset_cmd();
    test_set_and_skip();
    test_back_to_back();
    test_ignore_while_busy();
    test_reset_mid_pulse();
    test_reset_with_accept();
    test_fbcheck();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_pulse_driver.md
SR_PULSE_DRIVER -- requirements
Module: sr_pulse_driver

Interface
REQ-001 Parameter PULSE_W, default 2, cycles S or R is held high per command (legal range 1..15).
REQ-002 Parameter DEAD_T, default 1, idle cycles after each pulse before done (legal range 1..15).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port req  input  1  command valid; accepted only when req and ready are both 1 on a rising edge.
REQ-006 Port target  input  1  requested latch level: 1 = set, 0 = reset; sampled on acceptance.
REQ-007 Port q_fb  input  1  latch output fed back for the optional check.
REQ-008 Port ready  output  1  driver idle and able to accept a command.
REQ-009 Port s  output  1  registered set drive to the latch.
REQ-010 Port r  output  1  registered reset drive to the latch.
REQ-011 Port done  output  1  one-cycle pulse marking command completion.
REQ-012 Port q_model  output  1  driver's record of the last driven level.
REQ-013 Port known  output  1  q_model is valid; 0 until the first pulse completes.
REQ-014 Port err  output  1  sticky feedback-mismatch flag.

Function
REQ-015 FSM states IDLE, PULSE, DEAD, DONE; ready = 1 only in IDLE.
REQ-016 IDLE -> PULSE on acceptance when known = 0 or target != q_model.
REQ-017 IDLE -> DONE on acceptance when known = 1 and target == q_model (skip, no pulse on s/r).
REQ-018 Accept at edge N: s (target=1) or r (target=0) is high for cycles N+1 .. N+PULSE_W exactly.
REQ-019 PULSE -> DEAD after PULSE_W cycles; s = r = 0 throughout DEAD, lasting DEAD_T cycles.
REQ-020 DEAD -> DONE; done = 1 for exactly one cycle in DONE; DONE -> IDLE unconditionally.
REQ-021 q_model <= target and known <= 1 on the PULSE -> DEAD transition.
REQ-022 s and r are never high in the same cycle, under any input or reset sequence.
REQ-023 req while ready = 0 is ignored; no queuing; target changes outside acceptance are ignored.
REQ-024 Back-to-back: req held high is re-accepted on the IDLE cycle following DONE; total pulse-path period is PULSE_W + DEAD_T + 2 cycles.
REQ-025 Pulse and dead counters saturate at their load value and wrap to 0 only on state exit.

Reset
REQ-026 rst = 1 at an edge forces IDLE, s = 0, r = 0, done = 0, ready = 1 after that edge, regardless of state (including mid-pulse).
REQ-027 Reset values: q_model = 0, known = 0, err = 0; counters cleared.
REQ-028 A command accepted on the same edge as rst = 1 is discarded.

Configuration
REQ-029 Macro SR_DRV_FBCHECK_EN defined: in DONE after a pulse path, q_fb != q_model sets err = 1; err clears only on rst; skip path also checks q_fb.
REQ-030 SR_DRV_FBCHECK_EN undefined: q_fb unused, err tied to 0, all other behaviour identical.

Verification (PULSE_W=2, DEAD_T=1, q_fb wired to an ideal latch driven by s/r)
REQ-031 After rst, req=1 target=0 accepted at edge 0 -> r=1 cycles 1-2, s=0, dead cycle 3, done=1 cycle 4, ready=1 cycle 5, q_model=0, known=1.
REQ-032 From q_model=0, known=1: target=1 -> s=1 two cycles, done after 4 cycles, q_model=1; repeat target=1 -> no s/r activity, done=1 on the cycle after acceptance.
REQ-033 req held high, target alternating 1/0 -> s and r pulses each 2 cycles wide, >= 1 idle cycle between, one accept every 5 cycles, s&r never both 1.
REQ-034 rst asserted in second s cycle -> s=0 next cycle, ready=1, known=0, no done pulse.
REQ-035 SR_DRV_FBCHECK_EN defined, q_fb stuck 0, target=1 -> err=1 from DONE cycle, stays 1 until rst; macro undefined, same stimulus -> err=0.
